// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first.
// Full adder is two half_adder cells plus an OR of their carries.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             p0;
  logic             g0;
  logic             g1;
  logic             s_d;
  logic             c_d;
  logic [WIDTH-1:0] r_d;

  half_adder u_ha0 (
    .a_i(a_q[0]),
    .b_i(b_q[0]),
    .s_o(p0),
    .c_o(g0)
  );

  half_adder u_ha1 (
    .a_i(p0),
    .b_i(c_q),
    .s_o(s_d),
    .c_o(g1)
  );

  assign c_d = g0 | g1;
  assign r_d = {s_d, r_q[WIDTH-1:1]};

  // Handshake flags come from the state register alone.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign carry_out = cout_q;

  // FSM plus datapath: load, shift one bit per clock, publish on last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          r_q   <= r_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= r_d;
            cout_q  <= c_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carry_out(carry_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stimulus only: present operands, wait for out_valid, report latency.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat);
    int t = 0;
    while (!in_ready && t < 50) begin
      cyc();
      t++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL do_op_ready_timeout in_ready=%0b want 1", in_ready);
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      cyc();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cyc();
    cyc();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (sum !== 8'h00 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_result got %b_%h want 0_00", carry_out, sum);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_op(8'h35, 8'h4A, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency got %0d want 8", lat);
    end
    checks++;
    if (sum !== 8'h7F || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum got %b_%h want 0_7f", carry_out, sum);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h7F) begin
      errors++;
      $display("FAIL basic_after_hs vld=%b rdy=%b sum=%h want 0 1 7f",
               out_valid, in_ready, sum);
    end
  endtask

  task automatic test_ripple();
    int lat;
    do_op(8'hFF, 8'h01, lat);
    checks++;
    if (lat !== 8 || sum !== 8'h00 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL ripple got lat=%0d %b_%h want lat=8 1_00",
               lat, carry_out, sum);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    int lat;
    do_op(8'h35, 8'h4A, lat);
    a = 8'h11;
    b = 8'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
          sum !== 8'h7F || carry_out !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d vld=%b rdy=%b busy=%b %b_%h want 1 0 0 0_7f",
                 i, out_valid, in_ready, busy, carry_out, sum);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_load vld=%b busy=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_running busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        sum !== 8'h00 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state vld=%b busy=%b rdy=%b %b_%h want 0 0 1 0_00",
               out_valid, busy, in_ready, carry_out, sum);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_partial cycle%0d vld=%b want 0", i, out_valid);
      end
    end
    do_op(8'h80, 8'h80, lat);
    checks++;
    if (lat !== 8 || sum !== 8'h00 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_next got lat=%0d %b_%h want lat=8 1_00",
               lat, carry_out, sum);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    int gap;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W:0]   exp;
    int done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc();
      av = W'($urandom);
      bv = W'($urandom);
      exp = {1'b0, av} + {1'b0, bv};
      do_op(av, bv, lat);
      checks++;
      if (lat !== 8 || {carry_out, sum} !== exp) begin
        errors++;
        $display("FAIL rand%0d %h+%h got lat=%0d %h want lat=8 %h",
                 i, av, bv, lat, {carry_out, sum}, exp);
      end
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) cyc();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_dup vld=%b want 0", i, out_valid);
      end else begin
        done_cnt++;
      end
    end
    checks++;
    if (done_cnt !== 200) begin
      errors++;
      $display("FAIL rand_count got %0d want 200", done_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ripple();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
